// File: rtl/instr_mem_ctrl.sv
// Writable instruction memory for the RV32I fetch stage.
// Fills itself with FILL_WORD after reset, then serves fetches and accepts loader writes.
module instr_mem_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] FILL_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_fault,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              init_done
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]         rsp_fault_q, rsp_fault_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               mem_we_c;
  logic [IDX_W-1:0]   mem_waddr_c;
  logic [DATA_W-1:0]  mem_wdata_c;

  logic [ADDR_W-1:0]  req_idx, ld_idx;
  logic               req_mis, req_oor, ld_mis, ld_oor;
  logic               req_ready_c, ld_ready_c;

  // Byte address to word index; the wrapped subtraction is covered by the below-base test.
  assign req_idx = ADDR_W'((req_addr - BASE_ADDR) >> 2);
  assign ld_idx  = ADDR_W'((ld_addr - BASE_ADDR) >> 2);
  assign req_mis = (req_addr[1:0] != 2'b00);
  assign ld_mis  = (ld_addr[1:0] != 2'b00);
  assign req_oor = (req_addr < BASE_ADDR) || (req_idx >= ADDR_W'(DEPTH));
  assign ld_oor  = (ld_addr < BASE_ADDR) || (ld_idx >= ADDR_W'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Array is not reset; the INIT sweep rewrites every word.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = FILL_WORD;
    req_ready_c = 1'b0;
    ld_ready_c  = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        cnt_d       = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        req_ready_c = !rsp_valid_q || rsp_ready;
        ld_ready_c  = 1'b1;
        // Read reaches the array before this edge's write lands, giving read-first.
        if (req_valid && req_ready_c) begin
          rsp_valid_d = 1'b1;
          rsp_fault_d = {req_oor, req_mis};
          rsp_data_d  = (req_oor || req_mis) ? '0 : mem_q[req_idx[IDX_W-1:0]];
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
        if (ld_valid && !ld_mis && !ld_oor) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = ld_idx[IDX_W-1:0];
          mem_wdata_c = ld_data;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign req_ready = req_ready_c;
  assign ld_ready  = ld_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: directed vector table, corner sequences,
// and a randomized phase against a word-array reference model.
module tb_instr_mem_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] FILL  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_addr, rsp_data, ld_addr, ld_data;
  logic [1:0]  rsp_fault;
  logic        ld_valid, ld_ready, init_done;

  int num_tests = 0;
  int num_fail  = 0;

  logic [31:0] mdl [DEPTH];

  instr_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_tests++;
    if (act !== exp) begin
      num_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] mdl_fault(input logic [31:0] a);
    logic oor = (a / 4) >= DEPTH;
    return {oor, a[1:0] != 2'b00};
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    return (mdl_fault(a) != 2'b00) ? 32'h0 : mdl[a / 4];
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
    if (mdl_fault(a) == 2'b00) mdl[a / 4] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  // Releases reset and counts edges until init_done; also refills the model.
  task automatic wait_init(input string name);
    int cyc = 0;
    rst_n = 1'b1;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (init_done) break;
    end
    check(name, 32'(cyc), 32'd64);
    check({name, "_ldrdy"}, 32'(ld_ready), 32'd1);
    for (int i = 0; i < DEPTH; i++) mdl[i] = FILL;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
    mdl_write(a, d);
  endtask

  task automatic do_fetch(input string name, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic [1:0] exp_f);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    check({name, "_rdy"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check({name, "_vld"}, 32'(rsp_valid), 32'd1);
    check({name, "_data"}, rsp_data, exp_d);
    check({name, "_fault"}, 32'(rsp_fault), 32'(exp_f));
    tick();
    check({name, "_drain"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic [1:0]  exp_fault;
    string       name;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] held;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_fault;

    vecs[0]  = '{1'b1, 32'h0,   32'h0010_0093, 32'h0, 2'b00, "ld4"};
    vecs[1]  = '{1'b1, 32'h4,   32'h0010_0093, 32'h0, 2'b00, "ld4"};
    vecs[2]  = '{1'b1, 32'h8,   32'h0020_0113, 32'h0, 2'b00, "ld8"};
    vecs[3]  = '{1'b1, 32'hC,   32'h0030_0193, 32'h0, 2'b00, "ld12"};
    vecs[4]  = '{1'b0, 32'h0,   32'h0, 32'h0000_0013, 2'b00, "f0_after_ld0"};
    vecs[5]  = '{1'b0, 32'h6,   32'h0, 32'h0, 2'b01, "f_mis"};
    vecs[6]  = '{1'b0, 32'h100, 32'h0, 32'h0, 2'b10, "f_oor"};
    vecs[7]  = '{1'b1, 32'h102, 32'hCAFE_F00D, 32'h0, 2'b00, "ld_fault"};
    vecs[8]  = '{1'b0, 32'h100, 32'h0, 32'h0, 2'b10, "f_oor2"};
    vecs[9]  = '{1'b0, 32'hFC,  32'h0, 32'h0000_0013, 2'b00, "f_last"};
    vecs[10] = '{1'b0, 32'h101, 32'h0, 32'h0, 2'b11, "f_both"};
    // vecs[0] loads word 0 with data that vecs[4] expects overwritten; rewrite to FILL first
    vecs[0].data = 32'h0000_0013;

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_vld",   32'(rsp_valid), 32'd0);
    check("rst_data",  rsp_data,        32'd0);
    check("rst_fault", 32'(rsp_fault), 32'd0);
    check("rst_done",  32'(init_done), 32'd0);
    check("rst_rdy",   32'(req_ready), 32'd0);
    check("rst_ldrdy", 32'(ld_ready),  32'd0);
    @(posedge clk); #1;
    wait_init("init_cycles");

    do_fetch("f0_init", 32'h0, 32'h0000_0013, 2'b00);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_load) do_load(vecs[i].addr, vecs[i].data);
      else do_fetch(vecs[i].name, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_fault);
    end

    // Back-to-back fetches give responses on consecutive cycles.
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b1;
    tick();
    check("b2b_vld0", 32'(rsp_valid), 32'd1);
    check("b2b_d0", rsp_data, 32'h0010_0093);
    check("b2b_rdy", 32'(req_ready), 32'd1);
    req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    check("b2b_vld1", 32'(rsp_valid), 32'd1);
    check("b2b_d1", rsp_data, 32'h0020_0113);
    check("b2b_f1", 32'(rsp_fault), 32'd0);
    tick();

    // Backpressure: response held for 3 cycles, queued request waits.
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
    tick();
    held = rsp_data;
    check("bp_first", held, 32'h0010_0093);
    req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy", 32'(req_ready), 32'd0);
      check("bp_vld", 32'(rsp_valid), 32'd1);
      check("bp_hold", rsp_data, held);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_next", rsp_data, 32'h0020_0113);
    check("bp_next_vld", 32'(rsp_valid), 32'd1);
    tick();
    check("bp_drain", 32'(rsp_valid), 32'd0);
    check("bp_keep_data", rsp_data, 32'h0020_0113);

    // Same-edge load and fetch of one word returns the old word.
    req_valid = 1'b1; req_addr = 32'hC;
    ld_valid = 1'b1; ld_addr = 32'hC; ld_data = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0; ld_valid = 1'b0;
    mdl_write(32'hC, 32'hDEAD_BEEF);
    check("rf_old", rsp_data, 32'h0030_0193);
    tick();
    do_fetch("rf_new", 32'hC, 32'hDEAD_BEEF, 2'b00);

    // Randomized traffic against the reference model.
    e_valid = 1'b0; e_data = '0; e_fault = '0;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ra, la;
      logic        acc;
      check("rnd_vld", 32'(rsp_valid), 32'(e_valid));
      if (e_valid) begin
        check("rnd_data", rsp_data, e_data);
        check("rnd_fault", 32'(rsp_fault), 32'(e_fault));
      end
      case ($urandom_range(0, 9))
        0: ra = 32'h100 + 32'($urandom_range(0, 63)) * 4;
        1: ra = 32'($urandom_range(0, 255)) | 32'h1;
        default: ra = 32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
      la = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 511))
                                       : 32'($urandom_range(0, DEPTH - 1)) * 4;
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr  = ra;
      rsp_ready = ($urandom_range(0, 3) != 0);
      ld_valid  = ($urandom_range(0, 2) == 0);
      ld_addr   = la;
      ld_data   = $urandom;
      #1;
      acc = !e_valid || rsp_ready;
      check("rnd_rdy", 32'(req_ready), 32'(acc));
      if (req_valid && acc) begin
        e_valid = 1'b1; e_data = mdl_read(ra); e_fault = mdl_fault(ra);
      end else if (rsp_ready) begin
        e_valid = 1'b0;
      end
      if (ld_valid) mdl_write(la, ld_data);
      tick();
    end
    idle_inputs();
    tick();

    // Reset during a pending response, then re-init.
    do_load(32'h4, 32'h1234_5678);
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check("mr_pre_vld", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_vld", 32'(rsp_valid), 32'd0);
    check("mr_done", 32'(init_done), 32'd0);
    check("mr_rdy", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    wait_init("reinit_cycles");
    do_fetch("mr_f4", 32'h4, 32'h0000_0013, 2'b00);

    $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the RV32I core. It replaces hard-coded case-table ROMs with a writable word array. After reset, a hardware init sequence fills the array with NOPs. A loader port writes program words. Fetches use a valid/ready request/response handshake with 1-cycle read latency, backpressure and fault reporting for misaligned or out-of-range addresses. It sits between the fetch stage and the program loader / testbench.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 64, number of words in the array (≥2)
ADDR_W, 32, byte-address width of fetch and load ports
BASE_ADDR, 0, byte address mapped to word index 0 (word aligned)
FILL_WORD, 32'h00000013, value written to every word during init (ADDI x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted this cycle when high with req_valid
req_addr  in  ADDR_W  fetch byte address
rsp_valid  out  1  fetch response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  fetched instruction word
rsp_fault  out  2  [0]=misaligned, [1]=out of range; valid with rsp_valid
ld_valid  in  1  load write request
ld_ready  out  1  load write accepted when high with ld_valid
ld_addr  in  ADDR_W  load byte address
ld_data  in  DATA_W  load word
init_done  out  1  high once init fill is complete

Behaviour:
- Reset (async, rst_n=0): state=INIT, init counter=0, rsp_valid=0, rsp_data=0, rsp_fault=0, init_done=0, req_ready=0, ld_ready=0. Array contents are not reset directly; INIT rewrites them.
- FSM states:
  - INIT: writes FILL_WORD to index cnt each cycle, cnt++. After writing index DEPTH-1, goes to RUN. That is DEPTH cycles after reset release.
  - RUN: normal operation.
  - Reset asserted mid-INIT or mid-RUN returns to INIT immediately and re-fills. Any pending response is dropped.
- init_done=1 exactly in RUN. req_ready and ld_ready are 0 in INIT.
- Address decode, applied to both ports: off = addr - BASE_ADDR; idx = off >> 2.
  - misaligned = addr[1:0] != 0.
  - out_of_range = (addr < BASE_ADDR) or (idx ≥ DEPTH).
- Fetch handshake (RUN):
  - req_ready = !rsp_valid || rsp_ready (single-entry output register).
  - On accept (req_valid && req_ready) at edge N: at edge N+1, rsp_valid=1 and rsp_data=array[idx], or 0 if any fault. rsp_fault={out_of_range, misaligned}.
  - Back-to-back accepts give one response per cycle.
  - While rsp_valid && !rsp_ready: rsp_data and rsp_fault hold stable, req_ready=0.
  - Response consumed with no new accept: rsp_valid→0 next edge. rsp_data holds its last value.
- Load port (RUN): ld_ready=1.
  - On ld_valid, a write happens only if there is no fault; idx takes the word index. Faulting loads are silently discarded.
  - A write at edge N is visible to fetches accepted at edge N+1 or later.
  - Simultaneous load and fetch to the same idx at the same edge returns the OLD word (read-first).
- Widths: address arithmetic uses ADDR_W unsigned; the subtraction wrap is masked by the addr < BASE_ADDR check.
- Read is synchronous; there is no combinational path from req_addr to rsp_data.

Test Plan:
- Reset release with DEPTH=64: init_done rises after exactly 64 clk. A fetch of addr 0x0 then returns 0x00000013, fault=00.
- Load 0x00100093@4, 0x00200113@8, then fetch 4 and 8 back-to-back: responses on consecutive cycles are 0x00100093, 0x00200113, fault=00.
- Fetch addr 0x6 → rsp_data=0, rsp_fault=01. Fetch addr 0x100 (idx 64) → rsp_data=0, fault=10. Load to 0x102 is discarded; a later fetch of 0x100 is unchanged.
- Backpressure: hold rsp_ready=0 for 3 cycles after a response. rsp_data stays constant, req_ready=0. A request presented meanwhile is accepted only on the cycle rsp_ready rises.
- Same-edge load 0xDEADBEEF@12 and fetch@12 (old 0x00300193): the response is 0x00300193. The next fetch@12 returns 0xDEADBEEF.
- Assert rst_n=0 while rsp_valid=1 and the array is loaded: rsp_valid drops immediately. After re-init (64 cycles), a fetch of 4 returns 0x00000013.
